// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit-side controllers.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACT  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_CLR  = 3'd4
  } state_t;

  localparam int DEFAULT_N_REQ          = 4;
  localparam int DEFAULT_ACTIVE_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request strictly after
// the pointer (wrapping around, pointer position checked last) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan ptr+1 .. ptr+N (mod N) and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte sources with round-robin grant,
// packet lock (grant held until a byte flagged last) and a fully
// sequenced DV / Active / Done / Done-clear handshake.
//
//   state       | meaning
//   S_IDLE      | arbitrate; issue only while uart_tx shows Active=0, Done=0
//   S_ISSUE     | DV and Ack high for this single cycle
//   S_WAIT_ACT  | wait for Active, bounded by ACTIVE_TIMEOUT clocks
//   S_WAIT_DONE | frame on the line, wait for Done
//   S_WAIT_CLR  | wait for Done to drop so uart_tx is idle again
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  N_REQ          = DEFAULT_N_REQ,
  parameter int  ACTIVE_TIMEOUT = DEFAULT_ACTIVE_TIMEOUT,
  localparam int IW             = $clog2(N_REQ),
  localparam int TW             = $clog2(ACTIVE_TIMEOUT + 1)
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Byte,
  input  logic [N_REQ-1:0]   i_Last,
  output logic [N_REQ-1:0]   o_Ack,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done,
  output logic [IW-1:0]      o_Grant_Id,
  output logic               o_Locked,
  output logic               o_Busy,
  output logic               o_Error
);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [TW-1:0] timer_q;
  logic          last_q;
  logic          rr_found;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] win_idx;
  logic          win;
  logic          lock_drop;
  logic          timeout;
  logic          tx_idle;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (i_Req),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // After a reset mid-frame uart_tx keeps running, so IDLE never issues
  // until the serialiser is visibly quiet.
  assign tx_idle = !i_Tx_Active && !i_Tx_Done;
  assign o_Busy  = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic, winner selection and lock release.
  always_comb begin
    state_d   = state_q;
    win       = 1'b0;
    win_idx   = o_Grant_Id;
    lock_drop = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (o_Locked && i_Req[o_Grant_Id]) begin
          win = tx_idle;
        end else begin
          // A locked owner that went quiet loses the lock and normal
          // round-robin takes over in the same cycle.
          lock_drop = o_Locked;
          win_idx   = rr_idx;
          win       = rr_found && tx_idle;
        end
        if (win) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (i_Tx_Active) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == '0) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (i_Tx_Done)  state_d = S_WAIT_CLR;
      S_WAIT_CLR:  if (!i_Tx_Done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: byte latch, handshake pulses, pointer, lock, timer, error.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Ack      <= '0;
      o_Grant_Id <= '0;
      o_Locked   <= 1'b0;
      o_Error    <= 1'b0;
      ptr_q      <= '0;
      timer_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      o_Ack   <= '0;
      case (state_q)
        S_IDLE: begin
          if (lock_drop) o_Locked <= 1'b0;
          if (win) begin
            o_Tx_Byte  <= i_Byte[8*int'(win_idx) +: 8];
            o_Grant_Id <= win_idx;
            last_q     <= i_Last[win_idx];
            o_Tx_DV    <= 1'b1;
            o_Ack      <= N_REQ'(1) << win_idx;
          end
        end
        S_ISSUE: begin
          ptr_q    <= o_Grant_Id;
          o_Locked <= ~last_q;
          timer_q  <= TW'(ACTIVE_TIMEOUT - 1);
        end
        S_WAIT_ACT: begin
          if (timeout) begin
            o_Error  <= 1'b1;
            o_Locked <= 1'b0;
          end else if (!i_Tx_Active) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx load
// (4 clocks per bit, Done held two cycles, no reset).
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [8*N-1:0] bytes = '0;
  logic [N-1:0]   ack;
  logic           dv;
  logic [7:0]     tx_byte;
  logic [1:0]     gid;
  logic           locked, busy, err;

  logic       u_act = 1'b0;
  int         u_t = 0;
  int         u_done_cnt = 0;
  logic       u_done;
  logic       stub = 1'b0;
  logic [9:0] fr = '0;

  logic [9:0] sent_q[$];
  logic [1:0] gq[$];
  logic       lq[$];
  logic [8:0] rq[N][$];

  int   n_chk = 0;
  int   n_err = 0;
  int   ack_bad = 0;
  int   ack_cnt[N];
  logic prev_dv = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .ACTIVE_TIMEOUT(16)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req       (req),
    .i_Byte      (bytes),
    .i_Last      (last),
    .o_Ack       (ack),
    .o_Tx_DV     (dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (u_act),
    .i_Tx_Done   (u_done),
    .o_Grant_Id  (gid),
    .o_Locked    (locked),
    .o_Busy      (busy),
    .o_Error     (err)
  );

  always #5 clk = ~clk;

  assign u_done = (u_done_cnt != 0);

  // uart_tx load: decodes the line mid-bit from the live o_Tx_Byte.
  always @(posedge clk) begin
    int bi;
    if (u_done_cnt != 0) u_done_cnt <= u_done_cnt - 1;
    if (!u_act) begin
      if (dv && !stub) begin
        u_act <= 1'b1;
        u_t   <= 0;
      end
    end else begin
      bi = u_t / 4;
      if (u_t % 4 == 2) begin
        if (bi == 0)      fr[0] = 1'b0;
        else if (bi == 9) fr[9] = 1'b1;
        else              fr[bi] = tx_byte[bi-1];
      end
      if (u_t == 39) begin
        u_act      <= 1'b0;
        u_done_cnt <= 2;
        sent_q.push_back(fr);
      end else begin
        u_t <= u_t + 1;
      end
    end
  end

  // Handshake monitor: one Ack per DV, DV one cycle wide.
  always @(negedge clk) begin
    if (dv) begin
      gq.push_back(gid);
      lq.push_back(locked);
      if ($countones(ack) != 1) ack_bad++;
      if (prev_dv) ack_bad++;
    end else if (ack != '0) begin
      ack_bad++;
    end
    for (int k = 0; k < N; k++) if (ack[k]) ack_cnt[k]++;
    prev_dv = dv;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        req[k]          = 1'b1;
        bytes[8*k +: 8] = rq[k][0][7:0];
        last[k]         = rq[k][0][8];
      end else begin
        req[k]  = 1'b0;
        last[k] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    drive();
  endtask

  task automatic put(input int k, input logic [7:0] b, input logic l);
    rq[k].push_back({l, b});
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int b = 0;
    while (!dv && b < budget) begin cycle(); b++; end
    chk(tag, dv, 1);
  endtask

  task automatic wait_frames(input string tag, input int n);
    int b = 0;
    while (sent_q.size() < n && b < 3000) begin cycle(); b++; end
    chk(tag, sent_q.size() >= n, 1);
  endtask

  task automatic wait_done_fall(input string tag);
    int b = 0;
    while (!u_done && b < 100) begin cycle(); b++; end
    while (u_done && b < 100) begin cycle(); b++; end
    chk(tag, u_done, 0);
  endtask

  task automatic pop_frame(input string tag, input logic [7:0] b);
    logic [9:0] f = 10'h3FF;
    if (sent_q.size() > 0) f = sent_q.pop_front();
    chk(tag, f, {1'b1, b, 1'b0});
  endtask

  task automatic pop_grant(input string tag, input logic [1:0] g, input logic l);
    logic [1:0] og = 2'bxx;
    logic       ol = 1'bx;
    if (gq.size() > 0) og = gq.pop_front();
    if (lq.size() > 0) ol = lq.pop_front();
    chk({tag, "_grant"}, og, g);
    chk({tag, "_locked"}, ol, l);
  endtask

  task automatic clear_logs();
    sent_q.delete();
    gq.delete();
    lq.delete();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    int g;
    int cyc;
    int fall_at;
    int dv_at;
    logic seen_hi;

    #2 rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_dv", dv, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", gid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", err, 0);

    // Single request from requester 2.
    clear_logs();
    put(2, 8'hA5, 1'b1);
    cycle();
    cycle();
    chk("single_dv", dv, 1);
    chk("single_ack", ack, 4'b0100);
    chk("single_grant", gid, 2);
    chk("single_byte", tx_byte, 8'hA5);
    wait_frames("single_frame_wait", 1);
    chk("single_frame", sent_q.size() > 0 ? sent_q.pop_front() : 10'h3FF, 10'h34A);
    wait_done_fall("single_done_fall");
    chk("single_busy_clr", busy, 1);
    cycle();
    chk("single_busy_idle", busy, 0);
    chk("single_unlocked", locked, 0);

    // All four requesting from a fresh pointer: order 1,2,3,0.
    do_reset();
    clear_logs();
    put(0, 8'h10, 1'b1);
    put(1, 8'h11, 1'b1);
    put(2, 8'h12, 1'b1);
    put(3, 8'h13, 1'b1);
    wait_frames("rr_wait", 4);
    pop_frame("rr_f0", 8'h11);
    pop_frame("rr_f1", 8'h12);
    pop_frame("rr_f2", 8'h13);
    pop_frame("rr_f3", 8'h10);
    pop_grant("rr_g0", 1, 0);
    pop_grant("rr_g1", 2, 0);
    pop_grant("rr_g2", 3, 0);
    pop_grant("rr_g3", 0, 0);
    for (int k = 0; k < N; k++) chk($sformatf("rr_ack_cnt%0d", k), ack_cnt[k], 1);

    // Packet lock: requester 0 holds the grant over requester 1.
    clear_logs();
    put(0, 8'h01, 1'b0);
    put(0, 8'h02, 1'b0);
    put(0, 8'h03, 1'b1);
    cycle();
    wait_dv("lock_first_dv", 10);
    put(1, 8'h55, 1'b1);
    wait_frames("lock_wait", 4);
    pop_frame("lock_f0", 8'h01);
    pop_frame("lock_f1", 8'h02);
    pop_frame("lock_f2", 8'h03);
    pop_frame("lock_f3", 8'h55);
    pop_grant("lock_g0", 0, 0);
    pop_grant("lock_g1", 0, 1);
    pop_grant("lock_g2", 0, 1);
    pop_grant("lock_g3", 1, 0);

    // Lock abandon: requester 0 leaves a packet open, requester 3 follows.
    wait_done_fall("abandon_pre");
    clear_logs();
    put(0, 8'h21, 1'b0);
    cycle();
    wait_dv("abandon_first_dv", 10);
    put(3, 8'h33, 1'b1);
    wait_frames("abandon_wait1", 1);
    chk("abandon_locked", locked, 1);
    wait_done_fall("abandon_done_fall");
    g = 0;
    while (!dv && g < 20) begin cycle(); g++; end
    chk("abandon_gap", g, 2);
    chk("abandon_grant", gid, 3);
    chk("abandon_unlocked", locked, 0);
    wait_frames("abandon_wait2", 2);
    pop_frame("abandon_f0", 8'h21);
    pop_frame("abandon_f1", 8'h33);

    // Active timeout with a dead serialiser.
    wait_done_fall("timeout_pre");
    cycle();
    clear_logs();
    stub = 1'b1;
    put(1, 8'h77, 1'b1);
    cycle();
    wait_dv("timeout_dv", 10);
    chk("timeout_grant", gid, 1);
    for (int i = 0; i < 16; i++) cycle();
    chk("timeout_err_early", err, 0);
    chk("timeout_busy_early", busy, 1);
    cycle();
    chk("timeout_err", err, 1);
    chk("timeout_idle", busy, 0);
    chk("timeout_unlocked", locked, 0);
    stub = 1'b0;
    put(2, 8'h5A, 1'b1);
    wait_frames("timeout_after_wait", 1);
    pop_frame("timeout_after_f", 8'h5A);
    chk("timeout_err_sticky", err, 1);

    // Reset during data bit 3, with requester 1 pending.
    wait_done_fall("midrst_pre");
    cycle();
    clear_logs();
    put(0, 8'hC3, 1'b1);
    g = 0;
    while (!(u_act && u_t >= 17) && g < 100) begin cycle(); g++; end
    chk("midrst_reach_bit3", u_act, 1);
    rst = 1'b1;
    put(1, 8'h99, 1'b1);
    drive();
    #1;
    chk("midrst_dv", dv, 0);
    chk("midrst_byte", tx_byte, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_grant", gid, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_error", err, 0);
    cycle();
    cycle();
    rst = 1'b0;
    cyc = 0;
    fall_at = -1;
    dv_at = -1;
    seen_hi = 1'b0;
    while (dv_at < 0 && cyc < 200) begin
      cycle();
      cyc++;
      if (u_done) seen_hi = 1'b1;
      else if (seen_hi && fall_at < 0) fall_at = cyc;
      if (dv) dv_at = cyc;
    end
    chk("midrst_dv_seen", dv_at >= 0, 1);
    chk("midrst_frame_done_first", sent_q.size(), 1);
    chk("midrst_gap", dv_at - fall_at, 1);
    chk("midrst_grant_after", gid, 1);
    if (sent_q.size() > 0) void'(sent_q.pop_front());
    wait_frames("midrst_wait", 1);
    pop_frame("midrst_f", 8'h99);

    chk("onehot_ack", ack_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
